calc_unit: RTL

Parametrised, registered successor to the datapath calculation stage of the multi-cycle processor. Selects ALU operands from A/B registers, PC and immediate, and executes single-cycle ALU ops plus an iterative shift-add multiply. Results and an extended flag set (zero, negative, carry, overflow) are registered under a start/busy/done handshake with the control FSM.

---
 rtl/calc_if.sv | 36 +++
 rtl/calc_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_if.sv
// calc_if: operand, control and result bundle between the control FSM (master) and calc_unit (slave).
interface calc_if #(
    parameter int unsigned WIDTH = 16
);
    logic             input_start;
    logic [WIDTH-1:0] input_A;
    logic [WIDTH-1:0] input_B;
    logic [WIDTH-1:0] input_PC;
    logic [WIDTH-1:0] input_imm;
    logic [1:0]       input_ALUSrcA;
    logic [1:0]       input_ALUSrcB;
    logic [3:0]       input_ALUOp;
    logic             input_flags_en;

    logic [WIDTH-1:0] output_ALU;
    logic             output_Zero;
    logic             output_negative;
    logic             output_carry;
    logic             output_overflow;
    logic             output_busy;
    logic             output_done;

    modport master (
        output input_start, input_A, input_B, input_PC, input_imm,
               input_ALUSrcA, input_ALUSrcB, input_ALUOp, input_flags_en,
        input  output_ALU, output_Zero, output_negative, output_carry,
               output_overflow, output_busy, output_done
    );

    modport slave (
        input  input_start, input_A, input_B, input_PC, input_imm,
               input_ALUSrcA, input_ALUSrcB, input_ALUOp, input_flags_en,
        output output_ALU, output_Zero, output_negative, output_carry,
               output_overflow, output_busy, output_done
    );
endinterface

// File: rtl/calc_unit.sv
// calc_unit: registered ALU stage with operand muxing, extended flags and an
// iterative shift-add multiply under a start/busy/done handshake.
module calc_unit #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned PC_INC = 2
) (
    input  logic  clk,
    input  logic  reset,
    calc_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   op_a_c;
    logic [WIDTH-1:0]   op_b_c;
    logic [WIDTH-1:0]   res_c;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     diff_c;
    logic [SHW-1:0]     shamt_c;
    logic               carry_c;
    logic               ovf_c;
    logic               start_alu_c;
    logic               start_mul_c;
    logic               mul_last_c;
    logic [2*WIDTH-1:0] acc_next_c;

    logic [WIDTH-1:0]   alu_q;
    logic               zero_q;
    logic               neg_q;
    logic               carry_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     cnt_q;
    logic               flags_en_q;

    // Operand A select: 00 PC, 01 zero, 1x register A.
    always_comb begin
        op_a_c = bus.input_A;
        case (bus.input_ALUSrcA)
            2'b00:   op_a_c = bus.input_PC;
            2'b01:   op_a_c = '0;
            default: op_a_c = bus.input_A;
        endcase
    end

    // Operand B select: 00 B, 01 PC increment, 10 imm, 11 imm scaled by two.
    always_comb begin
        op_b_c = bus.input_B;
        case (bus.input_ALUSrcB)
            2'b00:   op_b_c = bus.input_B;
            2'b01:   op_b_c = WIDTH'(PC_INC);
            2'b10:   op_b_c = bus.input_imm;
            default: op_b_c = {bus.input_imm[WIDTH-2:0], 1'b0};
        endcase
    end

    assign shamt_c = op_b_c[SHW-1:0];
    assign sum_c   = {1'b0, op_a_c} + {1'b0, op_b_c};
    assign diff_c  = {1'b0, op_a_c} - {1'b0, op_b_c};

    // Single-cycle result and arithmetic flags; diff_c[WIDTH] is the unsigned borrow.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (bus.input_ALUOp)
            OP_ADD: begin
                res_c   = sum_c[MSB:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (op_a_c[MSB] == op_b_c[MSB]) && (sum_c[MSB] != op_a_c[MSB]);
            end
            OP_SUB: begin
                res_c   = diff_c[MSB:0];
                carry_c = diff_c[WIDTH];
                ovf_c   = (op_a_c[MSB] != op_b_c[MSB]) && (diff_c[MSB] != op_a_c[MSB]);
            end
            OP_AND:  res_c = op_a_c & op_b_c;
            OP_OR:   res_c = op_a_c | op_b_c;
            OP_XOR:  res_c = op_a_c ^ op_b_c;
            OP_SLL:  res_c = op_a_c << shamt_c;
            OP_SRL:  res_c = op_a_c >> shamt_c;
            OP_SRA:  res_c = $signed(op_a_c) >>> shamt_c;
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(op_a_c) < $signed(op_b_c))};
            default: res_c = '0;
        endcase
    end

    assign acc_next_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; starts are only seen in IDLE, so a start while busy is dropped.
    always_comb begin
        state_d     = state_q;
        start_alu_c = 1'b0;
        start_mul_c = 1'b0;
        mul_last_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.input_start) begin
                    if (bus.input_ALUOp == OP_MUL) begin
                        start_mul_c = 1'b1;
                        state_d     = S_MUL;
                    end else begin
                        start_alu_c = 1'b1;
                    end
                end
            end
            S_MUL: begin
                mul_last_c = (cnt_q == SHW'(WIDTH - 1));
                if (mul_last_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result, flags, handshake and multiply datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q      <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            flags_en_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_d == S_MUL);

            if (start_alu_c) begin
                alu_q  <= res_c;
                done_q <= 1'b1;
                if (bus.input_flags_en) begin
                    zero_q  <= (res_c == '0);
                    neg_q   <= res_c[MSB];
                    carry_q <= carry_c;
                    ovf_q   <= ovf_c;
                end
            end

            if (start_mul_c) begin
                mcand_q    <= {{WIDTH{1'b0}}, op_a_c};
                mplier_q   <= op_b_c;
                acc_q      <= '0;
                cnt_q      <= '0;
                flags_en_q <= bus.input_flags_en;
            end

            // One multiplier bit per cycle, LSB first; the last iteration writes the result.
            if (state_q == S_MUL) begin
                acc_q    <= acc_next_c;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + SHW'(1);
                if (mul_last_c) begin
                    alu_q  <= acc_next_c[MSB:0];
                    done_q <= 1'b1;
                    if (flags_en_q) begin
                        zero_q  <= (acc_next_c[MSB:0] == '0);
                        neg_q   <= acc_next_c[MSB];
                        carry_q <= |acc_next_c[2*WIDTH-1:WIDTH];
                        ovf_q   <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.output_ALU      = alu_q;
    assign bus.output_Zero     = zero_q;
    assign bus.output_negative = neg_q;
    assign bus.output_carry    = carry_q;
    assign bus.output_overflow = ovf_q;
    assign bus.output_busy     = busy_q;
    assign bus.output_done     = done_q;
endmodule
